metronome_arm_sequencer: RTL and testbench

Controller that drives the address port of the metronome arm ROM. It animates the arm by sweeping ROM entries 0 to 127 and back at a rate set by the tempo, so that one sweep lasts exactly one beat. It captures the ROM's registered output and presents the arm-tip coordinates to the VGA draw logic. It also issues a one-cycle beat pulse to the click or tone generator.

---
 rtl/metronome_arm_sequencer.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_metronome_arm_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/metronome_arm_sequencer.sv
// -----------------------------------------------------------------------------
// metronome_arm_sequencer
//
// Purpose:
//   Drives the address port of the metronome arm ROM. The arm is animated by
//   sweeping ROM entries 0..ADDR_MAX and back, one full sweep per beat. The
//   sweep rate comes from a phase accumulator fed by the clamped tempo. The
//   ROM's registered output is captured and presented as the arm-tip
//   coordinates, and a one-cycle beat pulse marks each sweep endpoint.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   run          1 = swing, 0 = return to rest (CENTER_ADDR) and stop
//   bpm[8:0]     tempo in beats per minute, clamped to [BPM_MIN, BPM_MAX]
//   frame_start  (only with METRO_VSYNC_LATCH_EN) one-cycle pulse per frame
//   rom_addr     registered ROM address
//   rom_q        ROM data, valid one clock after rom_addr is sampled
//   arm_x/arm_y  registered arm-tip coordinates (rom_q[18:9] / rom_q[8:0])
//   arm_valid    one-cycle pulse when arm_x/arm_y update
//   beat         one-cycle pulse when the sweep lands on 0 or ADDR_MAX
//   swinging     high while in the SWING state
//
// Optional feature:
//   METRO_VSYNC_LATCH_EN - when defined, captured ROM data is held in a
//   pending register and only presented on a frame_start cycle.
// -----------------------------------------------------------------------------
module metronome_arm_sequencer #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned DATA_WIDTH  = 19,
  parameter int unsigned CENTER_ADDR = 64,
  parameter int unsigned BPM_MIN     = 30,
  parameter int unsigned BPM_MAX     = 300
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [8:0]            bpm,
`ifdef METRO_VSYNC_LATCH_EN
  input  logic                  frame_start,
`endif
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [9:0]            arm_x,
  output logic [8:0]            arm_y,
  output logic                  arm_valid,
  output logic                  beat,
  output logic                  swinging
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] CENTER    = ADDR_WIDTH'(CENTER_ADDR);
  localparam logic [8:0]            BPM_LO    = 9'(BPM_MIN);
  localparam logic [8:0]            BPM_HI    = 9'(BPM_MAX);
  // Accumulator threshold for one address step; one sweep is ADDR_MAX steps.
  localparam logic [63:0] STEP_DIV =
    (64'(CLK_HZ) * 64'd60) / ((64'd1 << ADDR_WIDTH) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWING = 2'd1,
    ST_HOME  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
  logic                    dir_q, dir_d;
  logic [31:0]             acc_q, acc_d;
  logic                    pend_q, pend_d;
  logic                    fetch1_q, fetch1_d;
  logic                    fetch2_q, fetch2_d;
  logic [9:0]              arm_x_q, arm_x_d;
  logic [8:0]              arm_y_q, arm_y_d;
  logic                    arm_valid_q, arm_valid_d;
  logic                    beat_q, beat_d;
  logic                    swinging_q, swinging_d;

  logic [8:0]              bpm_c_s;
  logic [63:0]             sum_s;
  logic [31:0]             acc_next_s;
  logic                    step_s;
  logic                    req_s;
  logic                    move_s;
  logic [ADDR_WIDTH-1:0]   swing_tgt_s;
  logic [ADDR_WIDTH-1:0]   home_tgt_s;

  // Tempo clamp and phase accumulator.
  always_comb begin
    bpm_c_s    = bpm;
    step_s     = 1'b0;
    acc_next_s = acc_q;
    if (bpm < BPM_LO) begin
      bpm_c_s = BPM_LO;
    end else if (bpm > BPM_HI) begin
      bpm_c_s = BPM_HI;
    end else begin
      bpm_c_s = bpm;
    end
    sum_s = 64'(acc_q) + 64'(bpm_c_s);
    if (state_q == ST_IDLE) begin
      acc_next_s = 32'd0;
    end else if (sum_s >= STEP_DIV) begin
      step_s     = 1'b1;
      acc_next_s = 32'(sum_s - STEP_DIV);
    end else begin
      acc_next_s = 32'(sum_s);
    end
  end

  // Next-state, address stepping and beat generation.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    dir_d       = dir_q;
    acc_d       = acc_next_s;
    pend_d      = 1'b0;
    beat_d      = 1'b0;
    move_s      = 1'b0;
    // A step arriving while the previous address is still being fetched is
    // remembered and applied on the first clock the fetch allows it.
    req_s       = step_s | pend_q;
    swing_tgt_s = dir_q ? (rom_addr_q - ADDR_ONE) : (rom_addr_q + ADDR_ONE);
    home_tgt_s  = (rom_addr_q > CENTER) ? (rom_addr_q - ADDR_ONE)
                                        : (rom_addr_q + ADDR_ONE);
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_SWING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SWING: begin
        if (!run) begin
          state_d = ST_HOME;
          pend_d  = req_s;
        end else if (req_s && !fetch1_q) begin
          move_s     = 1'b1;
          rom_addr_d = swing_tgt_s;
          if ((swing_tgt_s == ADDR_MAX) || (swing_tgt_s == ADDR_ZERO)) begin
            beat_d = 1'b1;
            dir_d  = ~dir_q;
          end else begin
            beat_d = 1'b0;
          end
        end else begin
          pend_d = req_s;
        end
      end
      ST_HOME: begin
        if (run) begin
          state_d = ST_SWING;
          pend_d  = req_s;
        end else if (rom_addr_q == CENTER) begin
          state_d = ST_IDLE;
          dir_d   = 1'b0;
          acc_d   = 32'd0;
        end else if (req_s && !fetch1_q) begin
          move_s     = 1'b1;
          rom_addr_d = home_tgt_s;
          if (home_tgt_s == CENTER) begin
            state_d = ST_IDLE;
            dir_d   = 1'b0;
            acc_d   = 32'd0;
          end else begin
            state_d = ST_HOME;
          end
        end else begin
          pend_d = req_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dir_d   = 1'b0;
        acc_d   = 32'd0;
      end
    endcase
    // Fetch pipeline: address changes at E0, ROM samples at E1, capture at E2.
    fetch1_d   = move_s;
    fetch2_d   = fetch1_q;
    swinging_d = (state_d == ST_SWING);
  end

`ifdef METRO_VSYNC_LATCH_EN
  logic [9:0] lat_x_q, lat_x_d;
  logic [8:0] lat_y_q, lat_y_d;
  logic       dirty_q, dirty_d;

  // Capture into the frame latch; present only on frame_start.
  always_comb begin
    arm_x_d     = arm_x_q;
    arm_y_d     = arm_y_q;
    arm_valid_d = 1'b0;
    lat_x_d     = lat_x_q;
    lat_y_d     = lat_y_q;
    dirty_d     = dirty_q;
    if (fetch2_q && frame_start) begin
      // Fresh capture on a frame boundary wins over anything pending.
      arm_x_d     = rom_q[18:9];
      arm_y_d     = rom_q[8:0];
      arm_valid_d = 1'b1;
      dirty_d     = 1'b0;
    end else if (fetch2_q) begin
      lat_x_d = rom_q[18:9];
      lat_y_d = rom_q[8:0];
      dirty_d = 1'b1;
    end else if (frame_start && dirty_q) begin
      arm_x_d     = lat_x_q;
      arm_y_d     = lat_y_q;
      arm_valid_d = 1'b1;
      dirty_d     = 1'b0;
    end else begin
      dirty_d = dirty_q;
    end
  end

  // Frame latch registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_x_q <= 10'd0;
      lat_y_q <= 9'd0;
      dirty_q <= 1'b0;
    end else begin
      lat_x_q <= lat_x_d;
      lat_y_q <= lat_y_d;
      dirty_q <= dirty_d;
    end
  end
`else
  // Capture ROM data straight into the outputs at the end of a fetch.
  always_comb begin
    arm_x_d     = arm_x_q;
    arm_y_d     = arm_y_q;
    arm_valid_d = 1'b0;
    if (fetch2_q) begin
      arm_x_d     = rom_q[18:9];
      arm_y_d     = rom_q[8:0];
      arm_valid_d = 1'b1;
    end else begin
      arm_valid_d = 1'b0;
    end
  end
`endif

  // Main state and output registers; reset schedules a fetch of the rest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rom_addr_q  <= CENTER;
      dir_q       <= 1'b0;
      acc_q       <= 32'd0;
      pend_q      <= 1'b0;
      fetch1_q    <= 1'b1;
      fetch2_q    <= 1'b0;
      arm_x_q     <= 10'd0;
      arm_y_q     <= 9'd0;
      arm_valid_q <= 1'b0;
      beat_q      <= 1'b0;
      swinging_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      dir_q       <= dir_d;
      acc_q       <= acc_d;
      pend_q      <= pend_d;
      fetch1_q    <= fetch1_d;
      fetch2_q    <= fetch2_d;
      arm_x_q     <= arm_x_d;
      arm_y_q     <= arm_y_d;
      arm_valid_q <= arm_valid_d;
      beat_q      <= beat_d;
      swinging_q  <= swinging_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign arm_x     = arm_x_q;
  assign arm_y     = arm_y_q;
  assign arm_valid = arm_valid_q;
  assign beat      = beat_q;
  assign swinging  = swinging_q;

endmodule

// File: tb/tb_metronome_arm_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for metronome_arm_sequencer. A behavioural model (integer
// position, heading, phase and a short history of address changes) predicts
// every output on every clock; directed sequences and a tempo table cover the
// sweep endpoints, homing and the tempo clamp; a random phase exercises
// run/bpm/reset interleavings.
// -----------------------------------------------------------------------------
module tb_metronome_arm_sequencer;

  localparam int     CLK_HZ = 12700;
  localparam int     AMAX   = 127;
  localparam int     CENTER = 64;
  localparam longint DIV    = (longint'(CLK_HZ) * 60) / AMAX;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [8:0]  bpm;
  logic [6:0]  rom_addr;
  logic [18:0] rom_q;
  logic [9:0]  arm_x;
  logic [8:0]  arm_y;
  logic        arm_valid;
  logic        beat;
  logic        swinging;
`ifdef METRO_VSYNC_LATCH_EN
  logic        frame_start = 1'b0;
`endif

  logic [18:0] rom_mem [0:127];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // model state
  int     m_pos;
  int     m_head;
  int     m_mode;   // 0 rest, 1 swinging, 2 returning home
  longint m_phase;
  bit     m_owed;
  bit     c1, c2;   // address changed one / two edges ago
  int     c1_a, c2_a;
  int     e_x, e_y;
  bit     e_valid, e_beat;
`ifdef METRO_VSYNC_LATCH_EN
  int     l_x, l_y;
  bit     l_dirty;
`endif

  metronome_arm_sequencer #(
    .CLK_HZ(CLK_HZ)
  ) dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .bpm(bpm),
`ifdef METRO_VSYNC_LATCH_EN
    .frame_start(frame_start),
`endif
    .rom_addr(rom_addr),
    .rom_q(rom_q),
    .arm_x(arm_x),
    .arm_y(arm_y),
    .arm_valid(arm_valid),
    .beat(beat),
    .swinging(swinging)
  );

  always #5 clk = ~clk;

  // Registered ROM model.
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int  bc;
    int  np;
    bit  mv;
    e_valid = 1'b0;
    e_beat  = 1'b0;
    if (reset) begin
      m_pos = CENTER; m_head = 1; m_mode = 0; m_phase = 0; m_owed = 1'b0;
      c1 = 1'b1; c1_a = CENTER; c2 = 1'b0; c2_a = 0;
      e_x = 0; e_y = 0;
`ifdef METRO_VSYNC_LATCH_EN
      l_dirty = 1'b0;
`endif
      return;
    end
    // presentation of data fetched for the change two edges ago
`ifdef METRO_VSYNC_LATCH_EN
    if (c2 && frame_start) begin
      e_x = int'(rom_mem[c2_a][18:9]); e_y = int'(rom_mem[c2_a][8:0]);
      e_valid = 1'b1; l_dirty = 1'b0;
    end else if (c2) begin
      l_x = int'(rom_mem[c2_a][18:9]); l_y = int'(rom_mem[c2_a][8:0]);
      l_dirty = 1'b1;
    end else if (frame_start && l_dirty) begin
      e_x = l_x; e_y = l_y; e_valid = 1'b1; l_dirty = 1'b0;
    end
`else
    if (c2) begin
      e_x = int'(rom_mem[c2_a][18:9]); e_y = int'(rom_mem[c2_a][8:0]);
      e_valid = 1'b1;
    end
`endif
    // tempo: one step each time the phase crosses DIV
    bc = (bpm < 9'd30) ? 30 : ((bpm > 9'd300) ? 300 : int'(bpm));
    if (m_mode == 0) begin
      m_phase = 0;
    end else begin
      m_phase += bc;
      if (m_phase >= DIV) begin
        m_phase -= DIV;
        m_owed = 1'b1;
      end
    end
    mv = 1'b0;
    np = m_pos;
    case (m_mode)
      0: begin
        m_owed = 1'b0;
        if (run) m_mode = 1;
      end
      1: begin
        if (!run) m_mode = 2;
        else if (m_owed && !c1) begin
          mv = 1'b1; m_owed = 1'b0; np = m_pos + m_head;
          if (np == AMAX || np == 0) begin
            e_beat = 1'b1; m_head = -m_head;
          end
        end
      end
      2: begin
        if (run) m_mode = 1;
        else if (m_pos == CENTER) begin
          m_mode = 0; m_head = 1; m_phase = 0; m_owed = 1'b0;
        end else if (m_owed && !c1) begin
          mv = 1'b1; m_owed = 1'b0;
          np = (m_pos > CENTER) ? m_pos - 1 : m_pos + 1;
          if (np == CENTER) begin
            m_mode = 0; m_head = 1; m_phase = 0;
          end
        end
      end
      default: m_mode = 0;
    endcase
    m_pos = np;
    c2 = c1; c2_a = c1_a;
    c1 = mv; c1_a = np;
  endtask

  // One clock: model steps at the edge, outputs compared on the falling edge.
  task automatic tick();
`ifdef METRO_VSYNC_LATCH_EN
    frame_start = ((cyc % 37) == 36);
`endif
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check("cycle_model",
          {rom_addr, arm_x, arm_y, arm_valid, beat, swinging},
          {7'(m_pos), 10'(e_x), 9'(e_y), e_valid, e_beat, (m_mode == 1)});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic wait_addr_change(input int bound, output bit ok, output int at);
    logic [6:0] a0;
    a0 = rom_addr;
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (rom_addr != a0) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_beat(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (beat === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int bpm;
    int period;
  } tempo_vec_t;

  initial begin
    tempo_vec_t tv [8];
    bit ok;
    int t0, t1, c0, beats;

    tv[0] = '{0, 200};   tv[1] = '{29, 200};  tv[2] = '{30, 200};
    tv[3] = '{100, 60};  tv[4] = '{150, 40};  tv[5] = '{300, 20};
    tv[6] = '{301, 20};  tv[7] = '{511, 20};

    for (int i = 0; i < 128; i++) rom_mem[i] = 19'($urandom);
    reset = 1'b1;
    run   = 1'b0;
    bpm   = 9'd300;

    // reset and idle at rest
    repeat (3) tick();
    reset = 1'b0;
    tick();
`ifndef METRO_VSYNC_LATCH_EN
    check("rst_valid_early", {31'd0, arm_valid}, 32'd0);
`endif
    tick();
`ifndef METRO_VSYNC_LATCH_EN
    check("rst_valid", {31'd0, arm_valid}, 32'd1);
    check("rst_data", {arm_x, arm_y}, rom_mem[CENTER]);
`endif
    beats = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      beats += int'(beat);
    end
    check("idle_addr", rom_addr, 7'd64);
    check("idle_beats", beats, 0);

    // tempo clamp table
    for (int k = 0; k < 8; k++) begin
      do_reset();
      bpm = 9'(tv[k].bpm);
      run = 1'b1;
      c0  = cyc;
      wait_addr_change(400, ok, t0);
      check("tempo_first_seen", ok, 1'b1);
      check("tempo_first_addr", rom_addr, 7'd65);
      check("tempo_first_time", t0 - c0, tv[k].period + 1);
      wait_addr_change(400, ok, t1);
      check("tempo_second_seen", ok, 1'b1);
      check("tempo_period", t1 - t0, tv[k].period);
    end

    // full sweep: beat at 127, reverse, beat at 0 one beat later
    do_reset();
    bpm = 9'd300;
    run = 1'b1;
    c0  = cyc;
    wait_beat(3000, ok);
    check("beat1_seen", ok, 1'b1);
    check("beat1_addr", rom_addr, 7'd127);
    check("beat1_time", cyc - c0, 1261);
    t0 = cyc;
`ifndef METRO_VSYNC_LATCH_EN
    tick();
    tick();
    check("beat1_data", {arm_valid, arm_x, arm_y}, {1'b1, rom_mem[127]});
`endif
    wait_beat(3000, ok);
    check("beat2_seen", ok, 1'b1);
    check("beat2_addr", rom_addr, 7'd0);
    check("beat_interval", cyc - t0, 2540);

    // return home from address 100, then restart
    do_reset();
    bpm = 9'd300;
    run = 1'b1;
    for (int i = 0; i < 2000 && rom_addr != 7'd100; i++) tick();
    check("reach_100", rom_addr, 7'd100);
    run   = 1'b0;
    beats = 0;
    for (int i = 0; i < 1000 && rom_addr != 7'd64; i++) begin
      tick();
      beats += int'(beat);
    end
    check("home_addr", rom_addr, 7'd64);
    check("home_swinging", {31'd0, swinging}, 32'd0);
    for (int i = 0; i < 50; i++) begin
      tick();
      beats += int'(beat);
    end
    check("home_hold", rom_addr, 7'd64);
    check("home_beats", beats, 0);
    run = 1'b1;
    wait_addr_change(400, ok, t0);
    check("restart_seen", ok, 1'b1);
    check("restart_addr", rom_addr, 7'd65);

    // random run / tempo / reset interleavings against the model
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 1499) == 0) run = ~run;
      if ($urandom_range(0, 399) == 0)
        bpm = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(200, 300));
      reset = ($urandom_range(0, 4999) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
